// File: rtl/id_hazard_ctrl.sv
// Interlock/forwarding controller beside ID: drives PC and pipeline-register
// enables/flushes for load-use stalls, EX-resolved redirects and dmem freezes.
module id_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             ex_redirect,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  localparam logic [1:0] S_FREEZE = 2'd3;
  localparam logic [1:0] SQ_INIT  = 2'(FLUSH_CYCLES - 1);

  logic [1:0] squash_left, saved_state, saved_left;
  logic [1:0] eff_state, eff_left, state_nxt, left_nxt;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)   return 2'b01;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
    else                                                   return 2'b00;
  endfunction

  // FREEZE is transparent: decisions are made against the state it interrupted.
  assign eff_state = (state == S_FREEZE) ? saved_state : state;
  assign eff_left  = (state == S_FREEZE) ? saved_left  : squash_left;

  assign load_use = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = S_RUN;
    left_nxt   = 2'd0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (!reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
      if (dmem_wait) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        state_nxt = S_FREEZE;
        left_nxt  = squash_left;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = S_SQUASH;
          left_nxt  = SQ_INIT;
        end
      end else if (eff_state == S_SQUASH) begin
        ifid_flush = 1'b1;
        left_nxt   = 2'(eff_left - 2'd1);
        state_nxt  = (left_nxt == 2'd0) ? S_RUN : S_SQUASH;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        state_nxt  = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RUN;
      squash_left  <= 2'd0;
      saved_state  <= S_RUN;
      saved_left   <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state       <= state_nxt;
      squash_left <= left_nxt;
      if (dmem_wait) begin
        saved_state <= eff_state;
        saved_left  <= eff_left;
      end
      if (!pc_en && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: vector table for RUN-state strobes and
// forwarding, plus sequences for reset, redirect, squash, freeze and saturation.
module tb_id_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
  logic ex_redirect, dmem_wait;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic [31:0] stall_cycles;
  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_flush, s_idex_flush;
  logic [1:0] s_fwd_a, s_fwd_b, s_state;
  logic [3:0] s_stall_cycles;

  int errors = 0, checks = 0;
  logic [31:0] s0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .ex_redirect(ex_redirect), .dmem_wait(dmem_wait), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cycles(stall_cycles));

  id_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .ex_redirect(ex_redirect), .dmem_wait(dmem_wait), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .idex_en(s_idex_en), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .state(s_state), .stall_cycles(s_stall_cycles));

  typedef struct {
    logic iv; logic [4:0] rs1, rs2; logic u1, u2, mr; logic [4:0] exrd, xrs1, xrs2;
    logic mw; logic [4:0] mrd; logic ww; logic [4:0] wrd;
    logic stall; logic [1:0] fa, fb;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    {id_valid, id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write} = '0;
    {ex_redirect, dmem_wait} = '0;
    {id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd} = '0;
  endtask

  initial begin
    //         iv rs1 rs2 u1 u2 mr exrd xrs1 xrs2 mw mrd ww wrd stall fa fb
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00};
    vecs[2]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[3]  = '{1, 0, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[4]  = '{0, 0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{1, 9, 3, 1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00};
    vecs[6]  = '{1, 9, 3, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 7, 1, 7, 0, 2'b01, 2'b00};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 7, 1, 7, 0, 2'b10, 2'b00};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 0, 0, 2'b01, 2'b00};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 3, 9, 1, 9, 1, 9, 0, 2'b00, 2'b01};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 4, 0, 2'b00, 2'b10};

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      {id_valid, id_use_rs1, id_use_rs2, ex_mem_read} = 4'($urandom);
      {mem_reg_write, wb_reg_write, ex_redirect, dmem_wait} = 4'($urandom);
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_rd = 5'($urandom);
      ex_rs1 = 5'($urandom); ex_rs2 = 5'($urandom);
      mem_rd = 5'($urandom); wb_rd = 5'($urandom);
      #1;
      chk("rst_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
      chk("rst_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);
      chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
      chk("rst_cnt", stall_cycles, 32'd0);
      tick();
    end
    quiet();
    reset = 1'b1;
    tick();
    chk("rel_state", {30'd0, state}, 32'd0);
    chk("rel_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);

    // table: RUN-state hazard detection and forwarding
    for (int i = 0; i < 12; i++) begin
      id_valid = vecs[i].iv; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2; ex_mem_read = vecs[i].mr;
      ex_rd = vecs[i].exrd; ex_rs1 = vecs[i].xrs1; ex_rs2 = vecs[i].xrs2;
      mem_reg_write = vecs[i].mw; mem_rd = vecs[i].mrd;
      wb_reg_write = vecs[i].ww; wb_rd = vecs[i].wrd;
      #1;
      chk($sformatf("vec%0d_pc", i), {31'd0, pc_en}, {31'd0, !vecs[i].stall});
      chk($sformatf("vec%0d_ifid", i), {31'd0, ifid_en}, {31'd0, !vecs[i].stall});
      chk($sformatf("vec%0d_idexfl", i), {31'd0, idex_flush}, {31'd0, vecs[i].stall});
      chk($sformatf("vec%0d_rest", i), {28'd0, idex_en, exmem_en, memwb_en, ifid_flush}, 32'he);
      chk($sformatf("vec%0d_fwd", i), {28'd0, fwd_a, fwd_b}, {28'd0, vecs[i].fa, vecs[i].fb});
      tick();
    end

    // load-use: one bubble, then released
    quiet(); tick();
    s0 = stall_cycles;
    id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    #1;
    chk("lu_stall", {30'd0, pc_en, ifid_en}, 32'd0);
    chk("lu_flush", {31'd0, idex_flush}, 32'd1);
    tick();
    chk("lu_state", {30'd0, state}, 32'd1);
    chk("lu_cnt", stall_cycles, s0 + 1);
    ex_mem_read = 0;
    #1;
    chk("lu_release", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);
    tick();
    chk("lu_back_run", {30'd0, state}, 32'd0);

    // redirect: flush cycle, one squash cycle, RUN
    quiet(); ex_redirect = 1;
    #1;
    chk("rd_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);
    chk("rd_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);
    tick();
    ex_redirect = 0;
    #1;
    chk("sq_state", {30'd0, state}, 32'd2);
    chk("sq_flush", {30'd0, ifid_flush, idex_flush}, 32'd2);
    tick();
    chk("sq_done", {30'd0, state}, 32'd0);
    chk("sq_done_fl", {30'd0, ifid_flush, idex_flush}, 32'd0);

    // redirect during SQUASH restarts the squash count
    ex_redirect = 1; tick();
    chk("rr_state1", {30'd0, state}, 32'd2);
    #1;
    chk("rr_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);
    tick();
    ex_redirect = 0;
    #1;
    chk("rr_restart", {30'd0, state}, 32'd2);
    chk("rr_sqfl", {30'd0, ifid_flush, idex_flush}, 32'd2);
    tick();
    chk("rr_run", {30'd0, state}, 32'd0);

    // freeze entered from SQUASH with one squash slot left
    ex_redirect = 1; tick();
    ex_redirect = 0;
    chk("fz_from_sq", {30'd0, state}, 32'd2);
    s0 = stall_cycles;
    dmem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fz%0d_en", i), {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
      chk($sformatf("fz%0d_fl", i), {30'd0, ifid_flush, idex_flush}, 32'd0);
      tick();
      chk($sformatf("fz%0d_state", i), {30'd0, state}, 32'd3);
    end
    chk("fz_cnt", stall_cycles, s0 + 4);
    dmem_wait = 0;
    #1;
    chk("fz_resume_sq", {30'd0, ifid_flush, idex_flush}, 32'd2);
    chk("fz_resume_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);
    tick();
    chk("fz_run", {30'd0, state}, 32'd0);
    chk("fz_run_fl", {31'd0, ifid_flush}, 32'd0);

    // async reset clears the counter immediately
    dmem_wait = 1; tick();
    #2;
    reset = 0;
    #1;
    chk("async_cnt", stall_cycles, 32'd0);
    chk("async_state", {30'd0, state}, 32'd0);
    chk("async_fl", {30'd0, ifid_flush, idex_flush}, 32'd3);
    tick();
    dmem_wait = 0;
    reset = 1;

    // saturation on the 4-bit counter instance
    dmem_wait = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("sat15", {28'd0, s_stall_cycles}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", {28'd0, s_stall_cycles}, 32'd15);
    chk("wide20", stall_cycles, 32'd20);
    dmem_wait = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline interlock and forwarding controller for the 32I five-stage core. Sits beside the ID stage and drives the enable/flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves:
- load-use hazards, with a one-bubble stall;
- taken-branch/jump redirects resolved in EX, with a multi-cycle squash;
- data-memory wait states, with a full freeze.

It also produces the EX-operand forwarding selects and a saturating stall-cycle counter.

## Interface
- FLUSH_CYCLES, 2, fetch slots squashed after a redirect (legal 1..3)
- CNT_W, 32, width of stall_cycles
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- id_valid  in  1  ID slot holds a real (non-bubble) instruction
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  instruction in ID reads that source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination of the instruction in EX
- ex_rs1, ex_rs2  in  5 each  sources of the instruction in EX (forwarding)
- mem_reg_write, mem_rd  in  1, 5  writeback info of the instruction in MEM
- wb_reg_write, wb_rd  in  1, 5  writeback info of the instruction in WB
- ex_redirect  in  1  branch taken or jump in EX (PC loads target)
- dmem_wait  in  1  data memory not ready; whole pipeline must hold
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush  out  1 each  load a bubble instead of data
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM result, 10 WB result
- state  out  2  0 RUN, 1 LOAD_STALL, 2 SQUASH, 3 FREEZE
- stall_cycles  out  CNT_W  count of cycles with pc_en=0

## Operation

Combinational strobes are derived from state and inputs. The first matching rule wins:
1. **dmem_wait=1.** All five enables are 0 and both flushes are 0. Next state is FREEZE. The pre-freeze state and squash_left are saved and held.
2. **ex_redirect=1.** All enables are 1; ifid_flush=1, idex_flush=1. If FLUSH_CYCLES>1, next state is SQUASH with squash_left=FLUSH_CYCLES-1; otherwise next state is RUN.
3. **state=SQUASH.** All enables are 1; ifid_flush=1. squash_left decrements, and the state returns to RUN when it reaches 0.
4. **Load-use hazard.** The condition is id_valid, ex_mem_read, ex_rd≠0, and (id_use_rs1 with id_rs1==ex_rd, or id_use_rs2 with id_rs2==ex_rd). Then pc_en=0 and ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=1 and memwb_en=1. Next state is LOAD_STALL.
5. **Otherwise.** All enables are 1 and both flushes are 0. Next state is RUN.

Additional rules:
- **Leaving FREEZE.** On the first cycle with dmem_wait=0, the saved state and squash_left are restored, and rules 2-5 are evaluated against the restored state.
- **Redirect during freeze.** A redirect raised during FREEZE is acted on in that first non-wait cycle.
- **Redirect during SQUASH.** Rule 2 wins and restarts squash_left.
- **LOAD_STALL is informational only.** The next cycle is evaluated normally. The load is then in MEM and is forwarded, so no second bubble occurs.
- **Forwarding.**
  - fwd_a=01 if mem_reg_write, mem_rd≠0 and mem_rd==ex_rs1.
  - Otherwise fwd_a=10 if wb_reg_write, wb_rd≠0 and wb_rd==ex_rs1.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with ex_rs2.
  - MEM has priority over WB.
  - Forwarding is combinational and independent of state.
- **stall_cycles.** Increments each clock where pc_en=0, including freeze and load-use cycles. It saturates at all-ones and does not wrap.

## Timing
- **While reset=0.**
  - state=RUN, squash_left=0, stall_cycles=0.
  - All enables are 0; ifid_flush=1, idex_flush=1; fwd_a=fwd_b=00.
  - Reset is asserted asynchronously and released into RUN on the next rising clk edge.
- **State and counters** update on the rising clk edge only. Strobes are valid in the same cycle as their inputs (zero latency).
- **Load-use bubble.** Exactly 1 cycle per dependent load, unless dmem_wait extends it.
- **Redirect penalty.** The redirect cycle plus FLUSH_CYCLES-1 squash cycles.
- **Counter during reset.** Reset asserted mid-stall or mid-squash clears the counter immediately.

## Test plan
- **Reset.** Hold reset=0 for 3 cycles with random inputs -> all enables 0, both flushes 1, stall_cycles=0. Release reset -> state=0 next cycle.
- **Load-use.** ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, id_valid=1 -> pc_en=0, ifid_en=0, idex_flush=1, state=1 next edge, stall_cycles=1. Next cycle with ex_mem_read=0 -> all enables 1. Repeat with ex_rd=0 -> no stall.
- **Redirect.** ex_redirect pulse with FLUSH_CYCLES=2 -> ifid_flush=1 and idex_flush=1 in that cycle, then ifid_flush=1 for exactly 1 more cycle (state=2), then RUN. A second redirect during SQUASH -> squash_left restarts.
- **Freeze.** dmem_wait high for 4 cycles entered from SQUASH with squash_left=1 -> all enables 0 for 4 cycles, state=3, stall_cycles +4. Then exactly 1 squash cycle follows before RUN.
- **Forwarding.** mem_rd=wb_rd=ex_rs1=7, both write -> fwd_a=01. Clear mem_reg_write -> fwd_a=10. Set ex_rs2=0 with wb_rd=0 -> fwd_b=00.
- **Counter saturation.** CNT_W=4: hold dmem_wait for 20 cycles -> stall_cycles reaches 15 and stays at 15.
